// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Optional build macro: SIGNED_DIV_EN (two's complement operands, adds a FIXUP state).
package div_pkg;

  // FSM encoding; FIXUP is only reachable when SIGNED_DIV_EN is defined.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Wide all-ones pattern; users slice it down to their operand width.
  localparam logic [63:0] DIV_ALL_ONES = '1;

  // Step counter width: it must be able to hold the value w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nbit_addsub.sv
// Ripple-carry adder/subtractor: s = a + b (sub=0) or a - b (sub=1).
module nbit_addsub #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] c;
  logic           bx;

  // Bit-serial carry chain; b is inverted and the carry-in set for subtraction.
  always_comb begin
    c    = '0;
    s    = '0;
    bx   = 1'b0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      bx       = b[i] ^ sub;
      s[i]     = a[i] ^ bx ^ c[i];
      c[i+1]   = (a[i] & bx) | (c[i] & (a[i] ^ bx));
    end
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// One shift-and-trial-subtract step per cycle through a shared add/sub unit.
// Optional build macro: SIGNED_DIV_EN (signed operands, one extra FIXUP cycle).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
`endif

  logic [WIDTH-1:0] rs;
  logic [WIDTH:0]   as_a, as_b, sum;
  logic             cout;
  logic             trial_ok;
  logic [WIDTH-1:0] r_step, q_step;

`ifdef SIGNED_DIV_EN
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  nbit_addsub #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (1'b1),
    .s   (sum),
    .cout(cout)
  );

  // Add/sub operand select and the single restoring step.
  always_comb begin
    rs   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    as_a = {1'b0, rs};
    as_b = {1'b0, d_q};
`ifdef SIGNED_DIV_EN
    // FIXUP reuses the unit as a negator: 0 - quotient.
    if (state_q == FIXUP) begin
      as_a = '0;
      as_b = {1'b0, q_q};
    end
`endif
    // Borrow shows up as MSB set and carry clear; require both for a good trial.
    trial_ok = cout & ~sum[WIDTH];
    r_step   = trial_ok ? sum[WIDTH-1:0] : rs;
    q_step   = {q_q[WIDTH-2:0], trial_ok};
  end

  // Next-state logic for FSM, datapath registers and result registers.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          count_d = '0;
          r_d     = '0;
          dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
          q_d     = abs_val(dividend);
          d_d     = abs_val(divisor);
          neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_d = dividend[WIDTH-1];
`else
          q_d     = dividend;
          d_d     = divisor;
`endif
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = DIV_ALL_ONES[WIDTH-1:0];
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d     = r_step;
        q_d     = q_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
          state_d = FIXUP;
`else
          state_d = DONE;
          quot_d  = q_step;
          rem_d   = r_step;
`endif
        end
      end
`ifdef SIGNED_DIV_EN
      FIXUP: begin
        state_d = DONE;
        quot_d  = neg_q_q ? sum[WIDTH-1:0] : q_q;
        rem_d   = neg_r_q ? (~r_q + WIDTH'(1)) : r_q;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIXUP);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4).
// Honours SIGNED_DIV_EN when the same macro is defined for the build.
module tb_seq_restoring_divider;

  localparam int W = 4;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  localparam int NV = 9;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t tbl[NV];

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a request at the falling edge, let the rising edge accept it, then scramble operands.
  task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~dd;
    divisor  = ~dv;
  endtask

  // Called 1 time unit after the accept edge; lat counts cycles from accept to done.
  task automatic wait_done(output int lat, output bit saw_busy);
    lat      = 1;
    saw_busy = 1'b0;
    while (!done && lat < 100) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int           lat;
  bit           sb;
  int           ndone;
  int           done_cyc;
  logic [W-1:0] cq, cr;

  initial begin
`ifdef SIGNED_DIV_EN
    tbl[0] = '{4'd9,  4'd2,  4'hD, 4'hF, 1'b0};  // -7 / 2
    tbl[1] = '{4'd7,  4'hE,  4'hD, 4'd1, 1'b0};  //  7 / -2
    tbl[2] = '{4'd9,  4'hE,  4'd3, 4'hF, 1'b0};  // -7 / -2
    tbl[3] = '{4'd8,  4'hF,  4'd8, 4'd0, 1'b0};  // most-negative / -1
    tbl[4] = '{4'd7,  4'd0,  4'hF, 4'd7, 1'b1};
    tbl[5] = '{4'd6,  4'd3,  4'd2, 4'd0, 1'b0};
    tbl[6] = '{4'd8,  4'd0,  4'hF, 4'd8, 1'b1};
    tbl[7] = '{4'hD,  4'd4,  4'd0, 4'hD, 1'b0};  // -3 / 4
    tbl[8] = '{4'd1,  4'd1,  4'd1, 4'd0, 1'b0};
`else
    tbl[0] = '{4'd13, 4'd4,  4'd3, 4'd1, 1'b0};
    tbl[1] = '{4'd0,  4'd5,  4'd0, 4'd0, 1'b0};
    tbl[2] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
    tbl[3] = '{4'd7,  4'd0,  4'hF, 4'd7, 1'b1};
    tbl[4] = '{4'd14, 4'd3,  4'd4, 4'd2, 1'b0};
    tbl[5] = '{4'd3,  4'd7,  4'd0, 4'd3, 1'b0};
    tbl[6] = '{4'd9,  4'd2,  4'd4, 4'd1, 1'b0};
    tbl[7] = '{4'd15, 4'd2,  4'd7, 4'd1, 1'b0};
    tbl[8] = '{4'd8,  4'd1,  4'd8, 4'd0, 1'b0};
`endif

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single operations; each checks results, latency, busy and pulse width.
    for (int i = 0; i < NV; i++) begin
      start_op(tbl[i].dd, tbl[i].dv);
      wait_done(lat, sb);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].dbz ? 1 : LAT);
      check($sformatf("vec%0d_quotient", i), quotient, tbl[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, tbl[i].r);
      check($sformatf("vec%0d_dbz", i), div_by_zero, tbl[i].dbz);
      check($sformatf("vec%0d_busy_seen", i), sb, !tbl[i].dbz);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_held_q", i), quotient, tbl[i].q);
    end

    // Back-to-back: start held high in the DONE cycle.
    start_op(4'd15, 4'd1);
    wait_done(lat, sb);
    check("b2b_first_latency", lat, LAT);
    check("b2b_first_quotient", quotient, 4'hF);
    check("b2b_first_remainder", remainder, 4'd0);
    dividend = 4'd5;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    check("b2b_no_gap_busy", busy, 1);
    wait_done(lat, sb);
    check("b2b_second_latency", lat, LAT);
    check("b2b_second_quotient", quotient, 4'd1);
    check("b2b_second_remainder", remainder, 4'd2);

    // start pulsed during a run must be ignored.
    start_op(4'd12, 4'd5);
    ndone    = 0;
    done_cyc = 0;
    cq       = '0;
    cr       = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
      end else if (c == 3) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
        cq       = quotient;
        cr       = remainder;
      end
      @(posedge clk);
      #1;
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_latency", done_cyc, LAT);
`ifdef SIGNED_DIV_EN
    check("ignore_quotient", cq, 4'd0);
    check("ignore_remainder", cr, 4'hC);
`else
    check("ignore_quotient", cq, 4'd2);
    check("ignore_remainder", cr, 4'd2);
`endif

    // Asynchronous reset in the middle of a run.
    start_op(4'd12, 4'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_done", done, 0);
    start_op(4'd6, 4'd3);
    wait_done(lat, sb);
    check("after_abort_latency", lat, LAT);
    check("after_abort_quotient", quotient, 4'd2);
    check("after_abort_remainder", remainder, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
